// File: rtl/prog_loader_pkg.sv
// Shared encodings for the program loader: host command opcodes and controller states.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    OP_IWR   = 2'b00,
    OP_DWR   = 2'b01,
    OP_START = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_e;

  function automatic logic is_write(input op_e op);
    return (op == OP_IWR) || (op == OP_DWR);
  endfunction

endpackage

// File: rtl/prog_loader_fifo.sv
// Synchronous command FIFO with fall-through read; i_push/i_pop must already be qualified
// by the caller. o_ready is registered from the next occupancy, so it is low during reset.
module prog_loader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_ready;

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == (AW+1)'(0));
  assign o_ready = r_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !i_pop) begin
      w_count_nxt = r_count + (AW+1)'(1);
    end else if (!i_push && i_pop) begin
      w_count_nxt = r_count - (AW+1)'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Host-side loader/run controller for processor_top. Optional feature macro:
// LOAD_CHECKSUM_EN adds output load_sum, the wrapping sum of every word written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_word,
  input  logic              abort,
  output logic              core_rst,
  output logic              ins_we,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_out,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] load_sum
`endif
);

  localparam int CMD_W = 2 + ADDR_W + DATA_W;

  state_e            r_state, w_state_nxt;
  logic [CMD_W-1:0]  w_head;
  logic              w_empty, w_ready, w_pop, w_timeout_hit;
  op_e               w_op;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_word;
  logic [CNT_W-1:0]  w_cnt_inc;

  logic              r_core_rst, r_ins_we, r_data_we, r_busy, r_result_valid, r_timed_out;
  logic [ADDR_W-1:0] r_instr_addr, r_data_addr;
  logic [DATA_W-1:0] r_instr, r_data, r_result;
  logic [CNT_W-1:0]  r_cycle_count;

  prog_loader_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_valid && w_ready),
    .i_pop   (w_pop),
    .i_wdata ({cmd_op, cmd_addr, cmd_word}),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_ready (w_ready)
  );

  assign w_op   = op_e'(w_head[CMD_W-1 -: 2]);
  assign w_addr = w_head[DATA_W +: ADDR_W];
  assign w_word = w_head[DATA_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; the queue is frozen while the core runs
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (abort)              w_state_nxt = IDLE;
        else if (core_done)     w_state_nxt = DONE;
        else if (w_timeout_hit) w_state_nxt = TIMEOUT;
        else                    w_state_nxt = RUN;
      end
      IDLE, LOAD, DONE, TIMEOUT: begin
        if (w_pop) begin
          if (is_write(w_op))         w_state_nxt = LOAD;
          else if (w_op == OP_START)  w_state_nxt = RUN;
          else                        w_state_nxt = IDLE;
        end else if (r_state == LOAD) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pop/decode strobes and the saturating run counter increment
  always_comb begin
    w_pop         = !w_empty && (r_state != RUN);
    w_timeout_hit = (r_cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
    if (r_cycle_count == {CNT_W{1'b1}}) w_cnt_inc = r_cycle_count;
    else                                w_cnt_inc = r_cycle_count + CNT_W'(1);
  end

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_load_sum;
  assign load_sum = r_load_sum;
`endif

  // Registered outputs: memory write ports, core reset and run status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_rst     <= 1'b1;
      r_ins_we       <= 1'b0;
      r_data_we      <= 1'b0;
      r_instr_addr   <= '0;
      r_instr        <= '0;
      r_data_addr    <= '0;
      r_data         <= '0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_timed_out    <= 1'b0;
      r_cycle_count  <= '0;
`ifdef LOAD_CHECKSUM_EN
      r_load_sum     <= '0;
`endif
    end else begin
      r_ins_we   <= 1'b0;
      r_data_we  <= 1'b0;
      r_core_rst <= (w_state_nxt != RUN);
      r_busy     <= (w_state_nxt == LOAD) || (w_state_nxt == RUN);
      if (r_state == RUN) begin
        r_cycle_count <= w_cnt_inc;
        if (!abort && core_done) begin
          r_result       <= core_out;
          r_result_valid <= 1'b1;
        end else if (!abort && w_timeout_hit) begin
          r_timed_out <= 1'b1;
        end
      end else if (w_pop) begin
        case (w_op)
          OP_IWR: begin
            r_ins_we     <= 1'b1;
            r_instr_addr <= w_addr;
            r_instr      <= w_word;
`ifdef LOAD_CHECKSUM_EN
            r_load_sum   <= r_load_sum + w_word;
`endif
          end
          OP_DWR: begin
            r_data_we    <= 1'b1;
            r_data_addr  <= w_addr;
            r_data       <= w_word;
`ifdef LOAD_CHECKSUM_EN
            r_load_sum   <= r_load_sum + w_word;
`endif
          end
          OP_START: begin
            r_cycle_count  <= '0;
            r_result_valid <= 1'b0;
            r_timed_out    <= 1'b0;
          end
          OP_CLEAR: begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timed_out    <= 1'b0;
            r_cycle_count  <= '0;
`ifdef LOAD_CHECKSUM_EN
            r_load_sum     <= '0;
`endif
          end
          default: r_cycle_count <= r_cycle_count;
        endcase
      end
    end
  end

  assign cmd_ready    = w_ready;
  assign core_rst     = r_core_rst;
  assign ins_we       = r_ins_we;
  assign instr_addr   = r_instr_addr;
  assign instr        = r_instr;
  assign data_we      = r_data_we;
  assign data_addr    = r_data_addr;
  assign data         = r_data;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign timed_out    = r_timed_out;
  assign cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (TIMEOUT_CYCLES=16); checksum steps compile in with LOAD_CHECKSUM_EN.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, abort, core_rst, ins_we, data_we;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_addr, instr_addr, data_addr;
  logic [31:0] cmd_word, instr, data, core_out, result;
  logic        core_done, busy, result_valid, timed_out;
  logic [15:0] cycle_count;
`ifdef LOAD_CHECKSUM_EN
  logic [31:0] load_sum;
`endif

  int n_cmp = 0;
  int n_err = 0;

  prog_loader #(.DATA_W(32), .ADDR_W(10), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_word(cmd_word), .abort(abort), .core_rst(core_rst),
    .ins_we(ins_we), .instr_addr(instr_addr), .instr(instr), .data_we(data_we),
    .data_addr(data_addr), .data(data), .core_done(core_done), .core_out(core_out),
    .busy(busy), .result(result), .result_valid(result_valid), .timed_out(timed_out),
    .cycle_count(cycle_count)
`ifdef LOAD_CHECKSUM_EN
    , .load_sum(load_sum)
`endif
  );

  always #5 clk = ~clk;

  // Core model: raises done once it has been out of reset for done_at cycles
  logic done_en = 1'b0;
  int   done_at = 0;
  int   core_cnt = 0;
  always @(posedge clk) core_cnt <= core_rst ? 0 : core_cnt + 1;
  assign core_done = done_en && !core_rst && (core_cnt == done_at);

  // Write-strobe log, sampled mid-cycle
  logic        log_d [64];
  logic [9:0]  log_a [64];
  logic [31:0] log_w [64];
  int          log_n = 0;
  logic        both_seen = 1'b0;
  always @(negedge clk) begin
    if (ins_we && data_we) both_seen <= 1'b1;
    if ((ins_we || data_we) && log_n < 64) begin
      log_d[log_n] <= data_we;
      log_a[log_n] <= data_we ? data_addr : instr_addr;
      log_w[log_n] <= data_we ? data : instr;
      log_n        <= log_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [9:0] a, input logic [31:0] w);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_word  = w;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!cmd_ready && w < 40) begin
      tick();
      w++;
    end
    chk(tag, 64'(w < 40), 64'd1);
  endtask

  initial begin
    int mark;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 10'd0; cmd_word = 32'd0;
    abort = 1'b0; core_out = 32'd42;
    #12;
    chk("rst_core_rst", core_rst, 64'd1);
    chk("rst_cmd_ready", cmd_ready, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_result", result, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", cmd_ready, 64'd1);

    // Load three instructions and start; the core sees done in its 7th cycle
    done_en = 1'b1; done_at = 6;
    push(2'b00, 10'd0, 32'h01285020);
    chk("t1_we0_idle", ins_we, 64'd0);
    push(2'b00, 10'd1, 32'h014B4820);
    chk("t1_we_a", ins_we, 64'd1);
    chk("t1_addr_a", instr_addr, 64'd0);
    chk("t1_instr_a", instr, 64'h01285020);
    chk("t1_busy", busy, 64'd1);
    chk("t1_rst_a", core_rst, 64'd1);
    push(2'b00, 10'd2, 32'h00000008);
    chk("t1_we_b", ins_we, 64'd1);
    chk("t1_addr_b", instr_addr, 64'd1);
    chk("t1_instr_b", instr, 64'h014B4820);
    chk("t1_dwe_b", data_we, 64'd0);
    push(2'b10, 10'd0, 32'd0);
    chk("t1_we_c", ins_we, 64'd1);
    chk("t1_addr_c", instr_addr, 64'd2);
    chk("t1_instr_c", instr, 64'h8);
    chk("t1_rst_c", core_rst, 64'd1);
    tick();
    chk("t1_we_end", ins_we, 64'd0);
    chk("t1_run_rst", core_rst, 64'd0);
    chk("t1_run_cnt", cycle_count, 64'd0);

    for (int i = 0; i < 6; i++) tick();
    chk("t2_cnt6", cycle_count, 64'd6);
    chk("t2_rv_pre", result_valid, 64'd0);
    tick();
    chk("t2_result", result, 64'd42);
    chk("t2_rv", result_valid, 64'd1);
    chk("t2_cnt", cycle_count, 64'd7);
    chk("t2_core_rst", core_rst, 64'd1);
    chk("t2_busy", busy, 64'd0);
    chk("t2_to", timed_out, 64'd0);

    // Watchdog: no done, 16 cycles
    done_en = 1'b0;
    push(2'b10, 10'd0, 32'd0);
    chk("t3_rv_hold", result_valid, 64'd1);
    tick();
    chk("t3_rv_clr", result_valid, 64'd0);
    chk("t3_result_kept", result, 64'd42);
    chk("t3_cnt0", cycle_count, 64'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("t3_cnt15", cycle_count, 64'd15);
    chk("t3_to_pre", timed_out, 64'd0);
    chk("t3_rst_pre", core_rst, 64'd0);
    tick();
    chk("t3_to", timed_out, 64'd1);
    chk("t3_cnt16", cycle_count, 64'd16);
    chk("t3_rv", result_valid, 64'd0);
    chk("t3_core_rst", core_rst, 64'd1);

    // Fill the queue while running, then check drain order after the timeout
    push(2'b10, 10'd0, 32'd0);
    tick();
    chk("t4_running", core_rst, 64'd0);
    mark = log_n;
    push(2'b01, 10'd5, 32'hA5);
    push(2'b00, 10'd9, 32'h99);
    push(2'b01, 10'd6, 32'hB6);
    push(2'b01, 10'd7, 32'hC7);
    chk("t4_full", cmd_ready, 64'd0);
    chk("t4_no_we", 64'(ins_we || data_we), 64'd0);
    wait_ready("t4_wait5");
    push(2'b00, 10'd10, 32'h1010);
    wait_ready("t4_wait6");
    push(2'b01, 10'h3FF, 32'hDEAD);
    for (int i = 0; i < 10; i++) tick();
    chk("t4_log_n", 64'(log_n - mark), 64'd6);
    chk("t4_e0", {log_d[mark+0], log_a[mark+0], log_w[mark+0]}, {1'b1, 10'd5,    32'hA5});
    chk("t4_e1", {log_d[mark+1], log_a[mark+1], log_w[mark+1]}, {1'b0, 10'd9,    32'h99});
    chk("t4_e2", {log_d[mark+2], log_a[mark+2], log_w[mark+2]}, {1'b1, 10'd6,    32'hB6});
    chk("t4_e3", {log_d[mark+3], log_a[mark+3], log_w[mark+3]}, {1'b1, 10'd7,    32'hC7});
    chk("t4_e4", {log_d[mark+4], log_a[mark+4], log_w[mark+4]}, {1'b0, 10'd10,   32'h1010});
    chk("t4_e5", {log_d[mark+5], log_a[mark+5], log_w[mark+5]}, {1'b1, 10'h3FF,  32'hDEAD});
    chk("t4_to_kept", timed_out, 64'd1);
    chk("t4_idle", busy, 64'd0);

    // Clear wipes status
    push(2'b11, 10'd0, 32'd0);
    tick();
    chk("clr_result", result, 64'd0);
    chk("clr_to", timed_out, 64'd0);
    chk("clr_cnt", cycle_count, 64'd0);

    // Abort in RUN cycle 3 together with done
    done_en = 1'b1; done_at = 2; core_out = 32'd77;
    push(2'b10, 10'd0, 32'd0);
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; done_en = 1'b0;
    chk("t5_busy", busy, 64'd0);
    chk("t5_core_rst", core_rst, 64'd1);
    chk("t5_rv", result_valid, 64'd0);
    chk("t5_result", result, 64'd0);
    chk("t5_cnt", cycle_count, 64'd3);

    // Reset in the middle of a load, with a command still queued
    push(2'b00, 10'd1, 32'h11);
    push(2'b00, 10'd2, 32'h22);
    rst_n = 1'b0;
    #1;
    mark = log_n;
    chk("t5r_core_rst", core_rst, 64'd1);
    chk("t5r_outs", {ins_we, data_we, busy, result_valid, timed_out, cmd_ready}, 64'd0);
    chk("t5r_addr", {instr_addr, data_addr, cycle_count}, 64'd0);
    chk("t5r_data", {instr, data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t5r_flushed", 64'(log_n - mark), 64'd0);
    chk("t5r_ready", cmd_ready, 64'd1);
    chk("t5r_busy", busy, 64'd0);

`ifdef LOAD_CHECKSUM_EN
    push(2'b01, 10'd3, 32'hFFFFFFFF);
    push(2'b00, 10'd4, 32'h00000002);
    chk("t6_sum_a", load_sum, 64'hFFFFFFFF);
    tick();
    chk("t6_sum_b", load_sum, 64'd1);
    push(2'b11, 10'd0, 32'd0);
    tick();
    chk("t6_sum_clr", load_sum, 64'd0);
`endif

    chk("never_both_we", both_seen, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "bench timeout");
  end

endmodule
